// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
package mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

endpackage : mem_pkg

// File: rtl/mem_stage_if.sv
// Variable-latency request/acknowledge data-memory bus between mem_stage and memory.
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface : mem_stage_if

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the write-back controls and holds the data fields.
module mem_wb_reg
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bubble,
  input  logic                  i_reg_write,
  input  logic                  i_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] i_write_reg,
  input  logic [DATA_W-1:0]     i_alu_result,
  input  logic [DATA_W-1:0]     i_mem_data,
  output logic                  o_reg_write,
  output logic                  o_mem_to_reg,
  output logic [REG_ADDR_W-1:0] o_write_reg,
  output logic [DATA_W-1:0]     o_alu_result,
  output logic [DATA_W-1:0]     o_mem_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_write_reg  <= '0;
      o_alu_result <= '0;
      o_mem_data   <= '0;
    end else if (i_bubble) begin
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
    end else begin
      o_reg_write  <= i_reg_write;
      o_mem_to_reg <= i_mem_to_reg;
      o_write_reg  <= i_write_reg;
      o_alu_result <= i_alu_result;
      o_mem_data   <= i_mem_data;
    end
  end

endmodule : mem_wb_reg

// File: rtl/mem_stage.sv
// MIPS memory-access stage: data-memory bus FSM, pipeline stall and MEM/WB register.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write_in,
  input  logic                  mem_read_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [REG_ADDR_W-1:0] mux_reg_dst_out_in,
  input  logic [ADDR_W-1:0]     ALU_result_in,
  input  logic [DATA_W-1:0]     mux_ALU_src_B_out_in,
  mem_stage_if.master           dmem,
  output logic                  stall_out,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic [DATA_W-1:0]     ALU_result_out,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic                  mem_error_out
);

  state_t            r_state;
  state_t            w_next;
  logic              w_mem_op;
  logic              w_stall;
  logic              w_done;
  logic              w_timeout;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_wb_reg_write;
  logic [DATA_W-1:0] w_wb_mem_data;

  assign w_mem_op = mem_read_in | mem_write_in;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_error;

  // Counts ACCESS cycles; zero on the first one, so the last allowed cycle is TIMEOUT_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == IDLE) r_cnt <= '0;
      else                 r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign w_timeout     = (r_state == ACCESS) && !dmem.dmem_ack &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_error_out = r_error;
`else
  assign w_timeout     = 1'b0;
  assign mem_error_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and stall; an ack arriving with a timeout counts as normal completion.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          w_stall = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_timeout) begin
          w_next = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign stall_out = w_stall;

  // Bus address/data/direction latched on entry to ACCESS and held until the next access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_req <= (w_next == ACCESS);
      if ((r_state == IDLE) && w_mem_op) begin
        r_addr  <= ALU_result_in;
        r_wdata <= mux_ALU_src_B_out_in;
        r_we    <= mem_write_in;
      end
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

  assign w_wb_reg_write = reg_write_in & ~w_timeout;
  assign w_wb_mem_data  = (w_done && mem_read_in && !mem_write_in) ? dmem.dmem_rdata : '0;

  mem_wb_reg #(
    .DATA_W (DATA_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .i_bubble     (w_stall),
    .i_reg_write  (w_wb_reg_write),
    .i_mem_to_reg (mem_to_reg_in),
    .i_write_reg  (mux_reg_dst_out_in),
    .i_alu_result (DATA_W'(ALU_result_in)),
    .i_mem_data   (w_wb_mem_data),
    .o_reg_write  (reg_write_out),
    .o_mem_to_reg (mem_to_reg_out),
    .o_write_reg  (write_reg_out),
    .o_alu_result (ALU_result_out),
    .o_mem_data   (mem_data_out)
  );

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (timeout case only when MEM_TIMEOUT_EN is defined).
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        mem_write_in, mem_read_in, reg_write_in, mem_to_reg_in;
  logic [4:0]  mux_reg_dst_out_in;
  logic [31:0] ALU_result_in;
  logic [31:0] mux_ALU_src_B_out_in;
  logic        stall_out, reg_write_out, mem_to_reg_out, mem_error_out;
  logic [4:0]  write_reg_out;
  logic [31:0] ALU_result_out, mem_data_out;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

  mem_stage #(
    .ADDR_W (32),
    .DATA_W (32)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES (4)
`endif
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_write_in         (mem_write_in),
    .mem_read_in          (mem_read_in),
    .reg_write_in         (reg_write_in),
    .mem_to_reg_in        (mem_to_reg_in),
    .mux_reg_dst_out_in   (mux_reg_dst_out_in),
    .ALU_result_in        (ALU_result_in),
    .mux_ALU_src_B_out_in (mux_ALU_src_B_out_in),
    .dmem                 (dmem.master),
    .stall_out            (stall_out),
    .reg_write_out        (reg_write_out),
    .mem_to_reg_out       (mem_to_reg_out),
    .write_reg_out        (write_reg_out),
    .ALU_result_out       (ALU_result_out),
    .mem_data_out         (mem_data_out),
    .mem_error_out        (mem_error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mw, input logic mr, input logic rw, input logic m2r,
                       input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] wd);
    mem_write_in         = mw;
    mem_read_in          = mr;
    reg_write_in         = rw;
    mem_to_reg_in        = m2r;
    mux_reg_dst_out_in   = dst;
    ALU_result_in        = alu;
    mux_ALU_src_B_out_in = wd;
    #1;
  endtask

  task automatic set_ack(input logic ack, input logic [31:0] rdata);
    dmem.dmem_ack   = ack;
    dmem.dmem_rdata = rdata;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_ack(1'b0, 32'h0);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_req",   32'(dmem.dmem_req), 32'h0);
    check("rst_we",    32'(dmem.dmem_we), 32'h0);
    check("rst_addr",  dmem.dmem_addr, 32'h0);
    check("rst_wdata", dmem.dmem_wdata, 32'h0);
    check("rst_rw",    32'(reg_write_out), 32'h0);
    check("rst_wreg",  32'(write_reg_out), 32'h0);
    check("rst_alu",   ALU_result_out, 32'h0);
    check("rst_mdata", mem_data_out, 32'h0);
    check("rst_err",   32'(mem_error_out), 32'h0);
    check("rst_stall", 32'(stall_out), 32'h0);

    // ALU pass-through
    drive(0, 0, 1, 0, 5'd5, 32'h1234, 32'h0);
    check("alu_stall", 32'(stall_out), 32'h0);
    tick();
    check("alu_rw",    32'(reg_write_out), 32'h1);
    check("alu_wreg",  32'(write_reg_out), 32'd5);
    check("alu_res",   ALU_result_out, 32'h1234);
    check("alu_req",   32'(dmem.dmem_req), 32'h0);

    // Load from 0x40, ack on third ACCESS cycle
    drive(0, 1, 1, 1, 5'd7, 32'h40, 32'h0);
    check("ld_stall0", 32'(stall_out), 32'h1);
    tick();
    check("ld_req1",   32'(dmem.dmem_req), 32'h1);
    check("ld_addr1",  dmem.dmem_addr, 32'h40);
    check("ld_we1",    32'(dmem.dmem_we), 32'h0);
    check("ld_stall1", 32'(stall_out), 32'h1);
    check("ld_bubble", 32'(reg_write_out), 32'h0);
    tick();
    check("ld_req2",   32'(dmem.dmem_req), 32'h1);
    check("ld_addr2",  dmem.dmem_addr, 32'h40);
    check("ld_stall2", 32'(stall_out), 32'h1);
    tick();
    set_ack(1'b1, 32'hDEADBEEF);
    check("ld_req3",   32'(dmem.dmem_req), 32'h1);
    check("ld_addr3",  dmem.dmem_addr, 32'h40);
    check("ld_stall3", 32'(stall_out), 32'h0);
    tick();
    set_ack(1'b0, 32'h0);
    check("ld_data",   mem_data_out, 32'hDEADBEEF);
    check("ld_m2r",    32'(mem_to_reg_out), 32'h1);
    check("ld_rw",     32'(reg_write_out), 32'h1);
    check("ld_wreg",   32'(write_reg_out), 32'd7);
    check("ld_reqoff", 32'(dmem.dmem_req), 32'h0);

    // Store 0xCAFE to 0x80, immediate ack
    drive(1, 0, 0, 0, 5'd0, 32'h80, 32'hCAFE);
    check("st_stall0", 32'(stall_out), 32'h1);
    tick();
    check("st_req",    32'(dmem.dmem_req), 32'h1);
    check("st_we",     32'(dmem.dmem_we), 32'h1);
    check("st_wdata",  dmem.dmem_wdata, 32'hCAFE);
    check("st_addr",   dmem.dmem_addr, 32'h80);
    set_ack(1'b1, 32'h0BAD0BAD);
    check("st_stall1", 32'(stall_out), 32'h0);
    tick();
    set_ack(1'b0, 32'h0);
    check("st_rw",     32'(reg_write_out), 32'h0);
    check("st_mdata",  mem_data_out, 32'h0);
    check("st_reqoff", 32'(dmem.dmem_req), 32'h0);

    // Back-to-back loads with immediate acks: req 0,1,0,1
    drive(0, 1, 1, 1, 5'd1, 32'h100, 32'h0);
    check("bb_req0",   32'(dmem.dmem_req), 32'h0);
    tick();
    check("bb_req1",   32'(dmem.dmem_req), 32'h1);
    set_ack(1'b1, 32'h11111111);
    tick();
    set_ack(1'b0, 32'h0);
    drive(0, 1, 1, 1, 5'd2, 32'h104, 32'h0);
    check("bb_req2",   32'(dmem.dmem_req), 32'h0);
    check("bb_dataA",  mem_data_out, 32'h11111111);
    check("bb_wregA",  32'(write_reg_out), 32'd1);
    tick();
    check("bb_req3",   32'(dmem.dmem_req), 32'h1);
    check("bb_addrB",  dmem.dmem_addr, 32'h104);
    set_ack(1'b1, 32'h22222222);
    tick();
    set_ack(1'b0, 32'h0);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    check("bb_dataB",  mem_data_out, 32'h22222222);
    check("bb_wregB",  32'(write_reg_out), 32'd2);

    // Read and write both set: treated as a write, no load data
    drive(1, 1, 1, 1, 5'd9, 32'h300, 32'h77);
    tick();
    check("rw_we",     32'(dmem.dmem_we), 32'h1);
    set_ack(1'b1, 32'h99999999);
    tick();
    set_ack(1'b0, 32'h0);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    check("rw_mdata",  mem_data_out, 32'h0);
    check("rw_wreg",   32'(write_reg_out), 32'd9);

    // Reset in second ACCESS cycle, late ack ignored
    drive(0, 1, 1, 1, 5'd3, 32'h200, 32'h0);
    tick();
    tick();
    check("ra_req2",   32'(dmem.dmem_req), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    set_ack(1'b1, 32'h55555555);
    check("ra_req",    32'(dmem.dmem_req), 32'h0);
    check("ra_addr",   dmem.dmem_addr, 32'h0);
    check("ra_rw",     32'(reg_write_out), 32'h0);
    check("ra_alu",    ALU_result_out, 32'h0);
    check("ra_stall",  32'(stall_out), 32'h0);
    tick();
    set_ack(1'b0, 32'h0);
    check("ra_mdata",  mem_data_out, 32'h0);
    check("ra_req_b",  32'(dmem.dmem_req), 32'h0);
    check("ra_wreg",   32'(write_reg_out), 32'h0);

`ifdef MEM_TIMEOUT_EN
    // No ack: request held exactly four ACCESS cycles, then error and resume
    drive(0, 1, 1, 1, 5'd4, 32'h400, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("to_req%0d", i), 32'(dmem.dmem_req), 32'h1);
      check($sformatf("to_stall%0d", i), 32'(stall_out), (i == 4) ? 32'h0 : 32'h1);
    end
    tick();
    drive(0, 0, 1, 0, 5'd6, 32'h66, 32'h0);
    check("to_reqoff", 32'(dmem.dmem_req), 32'h0);
    check("to_err",    32'(mem_error_out), 32'h1);
    check("to_rw",     32'(reg_write_out), 32'h0);
    tick();
    check("to_resume", 32'(reg_write_out), 32'h1);
    check("to_res",    ALU_result_out, 32'h66);
    check("to_sticky", 32'(mem_error_out), 32'h1);
`else
    check("no_err",    32'(mem_error_out), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_stage
